// File: rtl/emac_tx_nibble_seq.sv
// MII transmit nibble sequencer: preamble/SFD, buffer-RAM prefetch of frame nibbles,
// inter-frame gap, abort handling and completion signalling.
module emac_tx_nibble_seq #(
    parameter int IFG_NIBBLES = 24,
    parameter int PRE_NIBBLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        tx_tick_i,
    input  logic        tx_start_i,
    input  logic [11:0] tx_base_i,
    input  logic [10:0] tx_len_i,
    input  logic        tx_abort_i,
    output logic        ce_a_o,
    output logic        wr_rd_n_a_o,
    output logic [11:0] adr_a_o,
    input  logic [3:0]  data_out_a_i,
    output logic [3:0]  txd_o,
    output logic        tx_en_o,
    output logic        tx_busy_o,
    output logic        tx_done_o,
    output logic        tx_aborted_o
);

    localparam int CNT_MAX = (IFG_NIBBLES > PRE_NIBBLES) ? IFG_NIBBLES : PRE_NIBBLES;
    localparam int TW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_IFG  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [11:0]   nib_cnt_q, nib_cnt_d;
    logic [11:0]   adr_q, adr_d;
    logic [3:0]    hold_q, hold_d;
    logic [3:0]    txd_q, txd_d;
    logic          tx_en_q, tx_en_d;
    logic          ce_q, ce_d;
    logic          cap_q, cap_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;

    logic start_ok;
    logic pre_last;
    logic nib_last;
    logic ifg_last;

    assign start_ok = tx_start_i && (tx_len_i != 11'd0);
    assign pre_last = (tick_cnt_q == TW'(PRE_NIBBLES));
    assign nib_last = (nib_cnt_q == 12'd1);
    assign ifg_last = (tick_cnt_q == TW'(IFG_NIBBLES - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort only matters while nibbles are being driven
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (tx_tick_i) begin
                    if (tx_abort_i) begin
                        state_d = S_IFG;
                    end else if (pre_last) begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tx_tick_i && (tx_abort_i || nib_last)) begin
                    state_d = S_IFG;
                end
            end
            S_IFG: begin
                if (tx_tick_i && ifg_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: counters, prefetch pipeline and registered MII outputs
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        nib_cnt_d  = nib_cnt_q;
        adr_d      = adr_q;
        hold_d     = hold_q;
        txd_d      = txd_q;
        tx_en_d    = tx_en_q;
        ce_d       = 1'b0;
        cap_d      = ce_q;
        done_d     = 1'b0;
        aborted_d  = aborted_q;

        // RAM read issued last cycle: advance address; data lands one cycle later
        if (ce_q) begin
            adr_d = adr_q + 12'd1;
        end
        if (cap_q) begin
            hold_d = data_out_a_i;
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    adr_d      = tx_base_i;
                    nib_cnt_d  = {tx_len_i, 1'b0};
                    tick_cnt_d = '0;
                    aborted_d  = 1'b0;
                end
            end
            S_PRE: begin
                if (tx_tick_i) begin
                    if (tx_abort_i) begin
                        txd_d      = 4'h0;
                        tx_en_d    = 1'b0;
                        aborted_d  = 1'b1;
                        tick_cnt_d = '0;
                    end else if (pre_last) begin
                        txd_d   = NIB_SFD;
                        tx_en_d = 1'b1;
                        ce_d    = 1'b1;
                    end else begin
                        txd_d      = NIB_PRE;
                        tx_en_d    = 1'b1;
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tx_tick_i) begin
                    if (tx_abort_i) begin
                        txd_d      = 4'h0;
                        tx_en_d    = 1'b0;
                        aborted_d  = 1'b1;
                        tick_cnt_d = '0;
                    end else begin
                        txd_d     = hold_q;
                        tx_en_d   = 1'b1;
                        nib_cnt_d = nib_cnt_q - 12'd1;
                        if (nib_last) begin
                            tick_cnt_d = '0;
                        end else begin
                            ce_d = 1'b1;
                        end
                    end
                end
            end
            S_IFG: begin
                if (tx_tick_i) begin
                    txd_d   = 4'h0;
                    tx_en_d = 1'b0;
                    if (ifg_last) begin
                        done_d     = 1'b1;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: begin
                tick_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_cnt_q <= '0;
            nib_cnt_q  <= '0;
            adr_q      <= '0;
            hold_q     <= '0;
            txd_q      <= '0;
            tx_en_q    <= 1'b0;
            ce_q       <= 1'b0;
            cap_q      <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            nib_cnt_q  <= nib_cnt_d;
            adr_q      <= adr_d;
            hold_q     <= hold_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            ce_q       <= ce_d;
            cap_q      <= cap_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    // Outputs
    always_comb begin
        ce_a_o       = ce_q;
        wr_rd_n_a_o  = 1'b0;
        adr_a_o      = adr_q;
        txd_o        = txd_q;
        tx_en_o      = tx_en_q;
        tx_busy_o    = (state_q != S_IDLE);
        tx_done_o    = done_q;
        tx_aborted_o = aborted_q;
    end

endmodule

// File: tb/tb_emac_tx_nibble_seq.sv
// Randomized bench for emac_tx_nibble_seq: expected MII nibble stream and RAM read
// sequence are derived from frame parameters by index arithmetic.
module tb_emac_tx_nibble_seq;

    localparam int IFG = 24;
    localparam int PRE = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_tick;
    logic        tx_start;
    logic [11:0] tx_base;
    logic [10:0] tx_len;
    logic        tx_abort;
    logic        ce_a;
    logic        wr_rd_n_a;
    logic [11:0] adr_a;
    logic [3:0]  data_out_a;
    logic [3:0]  txd;
    logic        tx_en;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_aborted;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  mem [4096];
    logic [11:0] rd_log [$];

    always #5 clk = ~clk;

    emac_tx_nibble_seq #(.IFG_NIBBLES(IFG), .PRE_NIBBLES(PRE)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .tx_tick_i    (tx_tick),
        .tx_start_i   (tx_start),
        .tx_base_i    (tx_base),
        .tx_len_i     (tx_len),
        .tx_abort_i   (tx_abort),
        .ce_a_o       (ce_a),
        .wr_rd_n_a_o  (wr_rd_n_a),
        .adr_a_o      (adr_a),
        .data_out_a_i (data_out_a),
        .txd_o        (txd),
        .tx_en_o      (tx_en),
        .tx_busy_o    (tx_busy),
        .tx_done_o    (tx_done),
        .tx_aborted_o (tx_aborted)
    );

    // Buffer RAM model with registered read; every read address is logged
    initial data_out_a = 4'h0;
    always @(posedge clk) begin
        if (ce_a) begin
            data_out_a <= mem[adr_a];
            rd_log.push_back(adr_a);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [11:0] base, input logic [10:0] len,
                             input int spacing, input int abort_tick, input bit noise);
        int n;
        int done_tick;
        int rd0;
        int prev_rd;
        int exp_reads;
        logic [3:0]  exp_txd;
        logic        exp_en;
        logic [11:0] a;
        n = 2 * int'(len);
        done_tick = (abort_tick >= 0) ? abort_tick + IFG : PRE + 1 + n + IFG - 1;
        rd0 = rd_log.size();
        tx_base = base; tx_len = len; tx_start = 1'b1;
        step();
        tx_start = 1'b0; tx_base = 12'($urandom); tx_len = 11'($urandom);
        n_vec++;
        if (tx_busy !== 1'b1) begin n_err++; $display("FAIL start_busy got %b exp 1", tx_busy); end
        n_vec++;
        if (tx_aborted !== 1'b0) begin n_err++; $display("FAIL start_aborted_clr got %b exp 0", tx_aborted); end
        prev_rd = rd_log.size();
        for (int t = 0; t <= done_tick; t++) begin
            if (noise && t == 5) begin
                tx_start = 1'b1; tx_len = 11'($urandom_range(1, 2047));
            end
            if (abort_tick >= 0 && t == abort_tick) tx_abort = 1'b1;
            if (noise && t == done_tick - 3) tx_abort = 1'b1;
            tx_tick = 1'b1;
            step();
            tx_tick = 1'b0; tx_start = 1'b0; tx_abort = 1'b0;
            if ((abort_tick >= 0 && t >= abort_tick) || t >= PRE + 1 + n) begin
                exp_en = 1'b0; exp_txd = 4'h0;
            end else if (t < PRE) begin
                exp_en = 1'b1; exp_txd = 4'h5;
            end else if (t == PRE) begin
                exp_en = 1'b1; exp_txd = 4'hD;
            end else begin
                a = base + 12'(t - PRE - 1);
                exp_en = 1'b1; exp_txd = mem[a];
            end
            n_vec++;
            if (tx_en !== exp_en || txd !== exp_txd) begin
                n_err++;
                $display("FAIL mii_nibble tick=%0d got en=%b txd=%h exp en=%b txd=%h",
                         t, tx_en, txd, exp_en, exp_txd);
            end
            n_vec++;
            if (tx_done !== (t == done_tick) || tx_busy !== (t != done_tick)) begin
                n_err++;
                $display("FAIL done_busy tick=%0d got done=%b busy=%b exp done=%b busy=%b",
                         t, tx_done, tx_busy, (t == done_tick), (t != done_tick));
            end
            for (int s = 1; s < spacing; s++) begin
                step();
                if (s == 1) begin
                    n_vec++;
                    if (tx_done !== 1'b0) begin n_err++; $display("FAIL done_width tick=%0d got %b exp 0", t, tx_done); end
                end
            end
            n_vec++;
            if (rd_log.size() - prev_rd > 1) begin
                n_err++;
                $display("FAIL reads_per_tick tick=%0d got %0d exp <=1", t, rd_log.size() - prev_rd);
            end
            prev_rd = rd_log.size();
        end
        if (abort_tick >= 0) exp_reads = (abort_tick > PRE) ? abort_tick - PRE : 0;
        else exp_reads = n;
        n_vec++;
        if (rd_log.size() - rd0 !== exp_reads) begin
            n_err++;
            $display("FAIL read_count got %0d exp %0d", rd_log.size() - rd0, exp_reads);
        end
        for (int i = 0; i < exp_reads && rd0 + i < rd_log.size(); i++) begin
            a = base + 12'(i);
            n_vec++;
            if (rd_log[rd0 + i] !== a) begin
                n_err++;
                $display("FAIL read_addr idx=%0d got %h exp %h", i, rd_log[rd0 + i], a);
            end
        end
        n_vec++;
        if (tx_aborted !== (abort_tick >= 0) || tx_busy !== 1'b0 || wr_rd_n_a !== 1'b0) begin
            n_err++;
            $display("FAIL end_status got aborted=%b busy=%b wr=%b exp aborted=%b busy=0 wr=0",
                     tx_aborted, tx_busy, wr_rd_n_a, (abort_tick >= 0));
        end
        $display("frame base=%h len=%0d spacing=%0d abort_tick=%0d noise=%0d done_tick=%0d",
                 base, len, spacing, abort_tick, noise, done_tick);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({txd, tx_en, ce_a, adr_a, tx_busy, tx_done, tx_aborted, wr_rd_n_a} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_state got txd=%h en=%b ce=%b adr=%h busy=%b done=%b ab=%b wr=%b exp all 0",
                     txd, tx_en, ce_a, adr_a, tx_busy, tx_done, tx_aborted, wr_rd_n_a);
        end
        #4 rst_n = 1'b1;
        step();
        $display("reset checked");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) mem[12'h010 + i] = 4'(i + 1);
        run_frame(12'h010, 11'd2, 4, -1, 1'b0);
    endtask

    task automatic test_wrap();
        run_frame(12'hFFE, 11'd2, 4, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_frame(12'($urandom), 11'($urandom_range(1, 40)),
                      $urandom_range(3, 6), -1, k[0]);
            repeat ($urandom_range(0, 5)) step();
        end
    endtask

    task automatic test_abort();
        run_frame(12'($urandom), 11'd64, 4, PRE + 1 + 2, 1'b0);
        run_frame(12'($urandom), 11'd10, 3, $urandom_range(0, PRE), 1'b0);
        run_frame(12'($urandom), 11'd10, 5, $urandom_range(PRE + 1, PRE + 20), 1'b1);
    endtask

    task automatic test_ignored_start();
        for (int k = 0; k < 4; k++) begin
            tx_start = 1'b1; tx_len = 11'd0; tx_base = 12'($urandom);
            tx_abort = k[0]; tx_tick = k[1];
            step();
            tx_start = 1'b0; tx_abort = 1'b0; tx_tick = 1'b0;
            step();
            n_vec++;
            if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_en !== 1'b0 || ce_a !== 1'b0) begin
                n_err++;
                $display("FAIL len0_ignored k=%0d got busy=%b done=%b en=%b ce=%b exp 0",
                         k, tx_busy, tx_done, tx_en, ce_a);
            end
            $display("len0 start k=%0d", k);
        end
        run_frame(12'($urandom), 11'($urandom_range(3, 12)), 4, -1, 1'b1);
    endtask

    task automatic test_reset_mid();
        tx_base = 12'($urandom); tx_len = 11'd4; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        for (int t = 0; t < PRE + 4; t++) begin
            tx_tick = 1'b1; step(); tx_tick = 1'b0;
            repeat (3) step();
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (tx_en !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0 || txd !== 4'h0 || ce_a !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got en=%b busy=%b done=%b txd=%h ce=%b exp 0",
                     tx_en, tx_busy, tx_done, txd, ce_a);
        end
        #10 rst_n = 1'b1;
        step();
        $display("reset mid-frame applied");
        run_frame(12'($urandom), 11'd1, 4, -1, 1'b0);
    endtask

    task automatic test_long();
        run_frame(12'($urandom), 11'd2047, 3, -1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom);
        rst_n = 1'b0; tx_tick = 1'b0; tx_start = 1'b0; tx_base = '0; tx_len = '0; tx_abort = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_random();
        test_abort();
        test_ignored_start();
        test_reset_mid();
        test_long();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
